lock_entry: RTL and testbench

LOCK_ENTRY -- requirements
Module: lock_entry

---
 rtl/lock_entry.sv | 164 ++++++++++++++++
 tb/tb_lock_entry.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_entry.sv
// Four-digit combination lock. Two bouncing push buttons are synchronised,
// debounced and edge-detected into single-cycle press pulses that drive a
// LOCKED / CHECK / OPEN / BLOCKED state machine. All outputs are registered
// from the next-state values, so they change on the same edge as the state.
module lock_entry #(
  parameter logic [15:0] CODE         = 16'h1234,
  parameter int          DB_COUNT     = 50000,
  parameter int          MAX_TRIES    = 3,
  parameter int          BLOCK_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       enter_btn,
  input  logic       clear_btn,
  output logic       unlock,
  output logic       override,
  output logic [2:0] digits
);

  localparam int DBW = $clog2(DB_COUNT + 1);
  localparam int TW  = $clog2(BLOCK_CYCLES + 1);
  localparam int FW  = $clog2(MAX_TRIES + 1);

  localparam logic [1:0] LOCKED  = 2'd0;
  localparam logic [1:0] CHECK   = 2'd1;
  localparam logic [1:0] OPEN    = 2'd2;
  localparam logic [1:0] BLOCKED = 2'd3;

  // Bit 0 is the enter button, bit 1 the clear button.
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {clear_btn, enter_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]     sync_reg;
      logic [DBW-1:0] db_cnt_reg;
      logic           level_reg;
      logic           level_d_reg;

      // Synchronise, then only follow the input once it has disagreed with
      // the debounced level for DB_COUNT consecutive cycles.
      always_ff @(posedge clk) begin
        if (!rst) begin
          sync_reg    <= 2'b00;
          db_cnt_reg  <= '0;
          level_reg   <= 1'b0;
          level_d_reg <= 1'b0;
        end else begin
          sync_reg    <= {sync_reg[0], btn_raw[gi]};
          level_d_reg <= level_reg;
          if (sync_reg[1] != level_reg) begin
            if (db_cnt_reg == DBW'(DB_COUNT - 1)) begin
              level_reg  <= sync_reg[1];
              db_cnt_reg <= '0;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end else begin
            db_cnt_reg <= '0;
          end
        end
      end

      // Rising edge of the debounced level; both flops clear on reset so no
      // pulse can straddle a reset.
      assign press[gi] = level_reg & ~level_d_reg;
    end
  endgenerate

  logic          press_enter;
  logic          press_clear;
  logic [1:0]    state_reg, state_next;
  logic [15:0]   entry_reg, entry_next;
  logic [2:0]    digits_reg, digits_next;
  logic [FW-1:0] fails_reg, fails_next;
  logic [TW-1:0] timer_reg, timer_next;

  assign press_enter = press[0];
  assign press_clear = press[1];

  // Next-state and datapath decisions for the lock.
  always_comb begin
    state_next  = state_reg;
    entry_next  = entry_reg;
    digits_next = digits_reg;
    fails_next  = fails_reg;
    timer_next  = timer_reg;
    case (state_reg)
      LOCKED: begin
        if (press_clear) begin
          // Clear takes priority over a coincident enter.
          entry_next  = 16'h0000;
          digits_next = 3'd0;
        end else if (press_enter) begin
          entry_next  = {entry_reg[11:0], sw};
          digits_next = digits_reg + 3'd1;
          if (digits_reg == 3'd3) begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        entry_next  = 16'h0000;
        digits_next = 3'd0;
        if (entry_reg == CODE) begin
          state_next = OPEN;
          fails_next = '0;
        end else if (fails_reg >= FW'(MAX_TRIES - 1)) begin
          state_next = BLOCKED;
          fails_next = FW'(MAX_TRIES);
          timer_next = TW'(BLOCK_CYCLES - 1);
        end else begin
          state_next = LOCKED;
          fails_next = fails_reg + 1'b1;
        end
      end
      OPEN: begin
        if (press_clear) begin
          state_next = LOCKED;
        end
      end
      BLOCKED: begin
        if (timer_reg == '0) begin
          state_next = LOCKED;
          fails_next = '0;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      default: begin
        state_next = LOCKED;
      end
    endcase
  end

  // State registers; unlock/override are decoded from the next state so they
  // line up with the state change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= LOCKED;
      entry_reg  <= 16'h0000;
      digits_reg <= 3'd0;
      fails_reg  <= '0;
      timer_reg  <= '0;
      unlock     <= 1'b0;
      override   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      entry_reg  <= entry_next;
      digits_reg <= digits_next;
      fails_reg  <= fails_next;
      timer_reg  <= timer_next;
      unlock     <= (state_next == OPEN);
      override   <= (state_next == BLOCKED);
    end
  end

  assign digits = digits_reg;

endmodule

// File: tb/tb_lock_entry.sv
// Bench for lock_entry: directed scenarios followed by random button
// transactions, all checked against a digit-queue model of the lock.
module tb_lock_entry;

  localparam logic [15:0] CODE = 16'h1234;
  localparam int DB = 4;
  localparam int MT = 3;
  localparam int BC = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       enter_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic       unlock;
  logic       override;
  logic [2:0] digits;

  lock_entry #(
    .CODE(CODE), .DB_COUNT(DB), .MAX_TRIES(MT), .BLOCK_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .enter_btn(enter_btn),
    .clear_btn(clear_btn), .unlock(unlock), .override(override),
    .digits(digits)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Model: 0 = locked, 1 = open, 2 = blocked; digits held in a queue.
  int         m_mode = 0;
  int         m_fails = 0;
  logic [3:0] m_buf[$];

  function automatic void m_reset();
    m_mode = 0;
    m_fails = 0;
    m_buf.delete();
  endfunction

  function automatic void m_enter(input logic [3:0] d);
    logic [15:0] v;
    if (m_mode != 0) return;
    m_buf.push_back(d);
    if (m_buf.size() == 4) begin
      v = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
      m_buf.delete();
      if (v == CODE) begin
        m_mode = 1;
        m_fails = 0;
      end else begin
        m_fails++;
        if (m_fails >= MT) m_mode = 2;
      end
    end
  endfunction

  function automatic void m_clear();
    if (m_mode == 0) m_buf.delete();
    else if (m_mode == 1) m_mode = 0;
  endfunction

  // Continuous monitors: exclusivity, blocked dwell, one-cycle CHECK.
  int ov_run = 0;
  int d4_run = 0;
  bit skip_dwell = 1'b0;
  bit hold_block = 1'b0;

  always @(negedge clk) begin
    if (unlock | override) check("exclusive", unlock & override, 0);
    if (override) ov_run++;
    else if (ov_run > 0) begin
      if (!skip_dwell) check("block_len", ov_run, BC);
      ov_run = 0;
    end
    if (digits == 3'd4) d4_run++;
    else if (d4_run > 0) begin
      check("check_len", d4_run, 1);
      d4_run = 0;
    end
  end

  task automatic check_outputs(input string tag);
    check({tag, "_unlock"}, unlock, (m_mode == 1) ? 1 : 0);
    check({tag, "_override"}, override, (m_mode == 2) ? 1 : 0);
    check({tag, "_digits"}, digits, m_buf.size());
  endtask

  // Blocked: press clear (enter still held) inside the window, then wait out
  // the block and confirm the lock returns empty.
  task automatic handle_block();
    clear_btn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("blk_ignore_ovr", override, 1);
    check("blk_ignore_dig", digits, 0);
    enter_btn = 1'b0;
    clear_btn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!override) break;
      @(posedge clk);
      #1;
    end
    check("block_end", override, 0);
    m_mode = 0;
    m_fails = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("post_block");
  endtask

  task automatic press(input bit e, input bit c, input logic [3:0] d);
    sw = d;
    enter_btn = e;
    clear_btn = c;
    repeat (12) @(posedge clk);
    #1;
    if (c) m_clear();
    else if (e) m_enter(d);
    $display("txn %0d: en=%0b clr=%0b sw=%h -> unlock=%0b override=%0b digits=%0d",
             n_vec, e, c, d, unlock, override, digits);
    check_outputs("press");
    if (m_mode == 2 && !hold_block) handle_block();
    enter_btn = 1'b0;
    clear_btn = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic attempt(input logic [15:0] c);
    for (int k = 0; k < 4; k++) press(1'b1, 1'b0, c[15-4*k -: 4]);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    check_outputs(tag);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] tbl [4];
    int op;
    logic [3:0] d;

    // Reset state.
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Correct code then relock.
    attempt(CODE);
    press(1'b0, 1'b1, 4'h0);

    // Three wrong attempts -> blocked window.
    for (int a = 0; a < 3; a++) attempt(16'h1235);

    // Bouncing enter settles into exactly one digit.
    sw = 4'h7;
    for (int i = 0; i < 15; i++) begin
      enter_btn = ~enter_btn;
      repeat (2) @(posedge clk);
    end
    enter_btn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    m_enter(4'h7);
    check("bounce_digits", digits, m_buf.size());
    enter_btn = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Short glitch accepts nothing.
    enter_btn = 1'b1;
    repeat (3) @(posedge clk);
    enter_btn = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_digits", digits, m_buf.size());
    press(1'b0, 1'b1, 4'h0);

    // Partial entry discarded, then correct code opens.
    press(1'b1, 1'b0, 4'h1);
    press(1'b1, 1'b0, 4'h2);
    press(1'b0, 1'b1, 4'h0);
    attempt(CODE);
    press(1'b0, 1'b1, 4'h0);

    // Coincident enter and clear: clear wins.
    press(1'b1, 1'b0, 4'h1);
    press(1'b1, 1'b0, 4'h2);
    press(1'b1, 1'b1, 4'h3);
    press(1'b0, 1'b1, 4'h0);

    // Wrong, wrong, right, wrong, then two more wrong: blocks on the last.
    tbl[0] = 16'h1111; tbl[1] = 16'h2222; tbl[2] = CODE; tbl[3] = 16'h1235;
    for (int a = 0; a < 4; a++) begin
      attempt(tbl[a]);
      if (m_mode == 1) press(1'b0, 1'b1, 4'h0);
    end
    attempt(16'h1235);
    attempt(16'h1235);

    // Reset while open.
    attempt(CODE);
    pulse_reset("rst_open");

    // Reset while blocked.
    hold_block = 1'b1;
    for (int a = 0; a < 3; a++) attempt(16'h0000);
    check("pre_rst_blocked", override, 1);
    skip_dwell = 1'b1;
    pulse_reset("rst_blocked");
    skip_dwell = 1'b0;
    hold_block = 1'b0;

    // Random transactions steered toward the code.
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 9);
      if (m_mode == 1 && ($urandom % 2) == 0) op = 0;
      if (($urandom % 4) != 0 && m_buf.size() < 4)
        d = CODE[15 - 4*m_buf.size() -: 4];
      else
        d = 4'($urandom_range(0, 15));
      if (op == 0) press(1'b0, 1'b1, d);
      else if (op == 1) press(1'b1, 1'b1, d);
      else press(1'b1, 1'b0, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
